axis_gain_ramp: RTL and testbench

- Parametrised successor to the fixed-shift switch volume stage in the I2S2 line-in to line-out path.
- Sits between the I2S2 receive AXIS master and transmit AXIS slave.
- Applies a per-channel multiplicative gain to a channel-interleaved AXIS audio stream.
- Gain slews toward its target once per frame, so gain changes are click-free; products saturate and support stall.

---
 rtl/axis_gain_ramp.sv | 190 +++++++++++++++++++
 tb/tb_axis_gain_ramp.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_gain_ramp.sv
// -----------------------------------------------------------------------------
// axis_gain_ramp
//
// Per-channel gain stage for a channel-interleaved AXIS audio stream. Each
// channel has its own current gain, which slews toward a target gain by at most
// RAMP_STEP per frame. This keeps gain changes click-free. Products are
// saturated to the sample range.
//
// Ports
//   axis_clk, axis_reset   clock, synchronous active-high reset
//   gain_target            per-channel target gain, ch c at [c*GAIN_W +: GAIN_W]
//   mute                   forces every channel's effective target to 0
//   s_axis_*               sample input (data / valid / ready / last)
//   m_axis_*               sample output (data / valid / ready / last)
//   ramp_busy              some channel's gain has not yet reached its target
//   sat_pulse              one cycle: the sample entering the output register
//                          was clipped
//   frame_err              one cycle after a last beat is accepted on a channel
//                          other than NUM_CH-1
//
// Handshake: a beat moves on a port when valid & ready are both high at a
// rising edge. The output register is stalled when m_axis_valid & ~m_axis_ready.
// While stalled, nothing in the block advances. s_axis_ready is ~stall &
// ~axis_reset. It depends on m_axis_ready combinationally, so a full pipeline
// can still move one beat per cycle.
// -----------------------------------------------------------------------------
module axis_gain_ramp #(
    parameter int DATA_W    = 24,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 16,
    parameter int FRAC_W    = 14,
    parameter int RAMP_STEP = 64
) (
    input  logic                     axis_clk,
    input  logic                     axis_reset,
    input  logic [NUM_CH*GAIN_W-1:0] gain_target,
    input  logic                     mute,
    input  logic [DATA_W-1:0]        s_axis_data,
    input  logic                     s_axis_valid,
    output logic                     s_axis_ready,
    input  logic                     s_axis_last,
    output logic [DATA_W-1:0]        m_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic                     ramp_busy,
    output logic                     sat_pulse,
    output logic                     frame_err
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int P_W  = DATA_W + GAIN_W + 1;

    localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [GAIN_W-1:0]     STEP    = GAIN_W'(RAMP_STEP);
    localparam logic signed [P_W-1:0] Q_MAX   = {{(P_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] Q_MIN   = {{(P_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]     D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    // Registers
    logic [CH_W-1:0]   ch_idx_q,    ch_idx_d;
    logic [GAIN_W-1:0] cur_gain_q [NUM_CH];
    logic [GAIN_W-1:0] cur_gain_d [NUM_CH];
    logic              s1_valid_q,  s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,   s1_data_d;
    logic              s1_last_q,   s1_last_d;
    logic [GAIN_W-1:0] s1_gain_q,   s1_gain_d;
    logic              m_valid_q,   m_valid_d;
    logic [DATA_W-1:0] m_data_q,    m_data_d;
    logic              m_last_q,    m_last_d;
    logic              sat_pulse_q, sat_pulse_d;
    logic              frame_err_q, frame_err_d;

    // Combinational helpers
    logic                     stall;
    logic                     accept;
    logic [GAIN_W-1:0]        eff_target [NUM_CH];
    logic signed [P_W-1:0]    data_ext;
    logic signed [P_W-1:0]    gain_ext;
    logic signed [P_W-1:0]    product;
    logic signed [P_W-1:0]    shifted;
    logic                     sat_hi;
    logic                     sat_lo;

    // One ramp step toward tgt. The step is clamped so that it never overshoots.
    function automatic logic [GAIN_W-1:0] ramp_toward(input logic [GAIN_W-1:0] cur,
                                                      input logic [GAIN_W-1:0] tgt);
        if (tgt > cur) begin
            return (tgt - cur > STEP) ? cur + STEP : tgt;
        end
        return (cur - tgt > STEP) ? cur - STEP : tgt;
    endfunction

    always_comb begin
        ramp_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            eff_target[c] = mute ? '0 : gain_target[c*GAIN_W +: GAIN_W];
            ramp_busy     = ramp_busy | (cur_gain_q[c] != eff_target[c]);
        end
    end

    always_comb begin
        stall        = m_valid_q & ~m_axis_ready;
        s_axis_ready = ~stall & ~axis_reset;
        accept       = s_axis_valid & s_axis_ready;

        // The gain is unsigned, so a zero is prepended before the signed multiply.
        data_ext = {{(P_W-DATA_W){s1_data_q[DATA_W-1]}}, s1_data_q};
        gain_ext = {{(P_W-GAIN_W){1'b0}}, s1_gain_q};
        product  = data_ext * gain_ext;
        shifted  = product >>> FRAC_W;
        sat_hi   = shifted > Q_MAX;
        sat_lo   = shifted < Q_MIN;

        ch_idx_d    = ch_idx_q;
        cur_gain_d  = cur_gain_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_last_d   = s1_last_q;
        s1_gain_d   = s1_gain_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        sat_pulse_d = 1'b0;
        frame_err_d = 1'b0;

        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = s_axis_data;
                s1_last_d = s_axis_last;
                s1_gain_d = cur_gain_q[ch_idx_q];
            end

            m_valid_d   = s1_valid_q;
            m_last_d    = s1_valid_q & s1_last_q;
            sat_pulse_d = s1_valid_q & (sat_hi | sat_lo);
            if (s1_valid_q) begin
                m_data_d = sat_hi ? D_MAX : (sat_lo ? D_MIN : shifted[DATA_W-1:0]);
            end
        end

        if (accept) begin
            ch_idx_d    = (s_axis_last || ch_idx_q == LAST_CH) ? '0 : ch_idx_q + 1'b1;
            frame_err_d = s_axis_last & (ch_idx_q != LAST_CH);
            // The last beat was already captured with the old gain above. The
            // new gain takes effect from the next beat.
            if (s_axis_last) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cur_gain_d[c] = ramp_toward(cur_gain_q[c], eff_target[c]);
                end
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            ch_idx_q    <= '0;
            cur_gain_q  <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_last_q   <= 1'b0;
            s1_gain_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            sat_pulse_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ch_idx_q    <= ch_idx_d;
            cur_gain_q  <= cur_gain_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_last_q   <= s1_last_d;
            s1_gain_q   <= s1_gain_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            sat_pulse_q <= sat_pulse_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign sat_pulse    = sat_pulse_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_axis_gain_ramp.sv
// Testbench for axis_gain_ramp. A reference model predicts every output beat
// from the gain and ramp rules. Directed cases cover the documented values,
// and a randomized backpressure run covers the rest.
module tb_axis_gain_ramp;
  localparam int DATA_W    = 24;
  localparam int NUM_CH    = 2;
  localparam int GAIN_W    = 16;
  localparam int FRAC_W    = 14;
  localparam int RAMP_STEP = 64;
  localparam int QW        = DATA_W + 2;   // {sat, last, data}

  // ---------------- clock / reset ----------------
  logic                     axis_clk;
  logic                     axis_reset;
  logic [NUM_CH*GAIN_W-1:0] gain_target;
  logic                     mute;
  logic [DATA_W-1:0]        s_axis_data;
  logic                     s_axis_valid;
  logic                     s_axis_ready;
  logic                     s_axis_last;
  logic [DATA_W-1:0]        m_axis_data;
  logic                     m_axis_valid;
  logic                     m_axis_ready;
  logic                     m_axis_last;
  logic                     ramp_busy;
  logic                     sat_pulse;
  logic                     frame_err;

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  axis_gain_ramp #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAIN_W(GAIN_W),
    .FRAC_W(FRAC_W), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .axis_clk(axis_clk), .axis_reset(axis_reset),
    .gain_target(gain_target), .mute(mute),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
    .ramp_busy(ramp_busy), .sat_pulse(sat_pulse), .frame_err(frame_err)
  );

  // ---------------- scoreboard state ----------------
  logic [QW-1:0]     exp_q[$];
  logic [QW-1:0]     out_log[$];
  int                gain_m[NUM_CH];
  int                ch_m;
  int                n_checks;
  int                n_pass;
  int                n_fail;
  int                n_prints;
  bit                checking;
  bit                exp_ferr;
  bit                stalled_prev;
  bit                last_in_fire;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_prints < 200) begin
        n_prints++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_of(input int c);
    return mute ? 0 : int'(gain_target[c*GAIN_W +: GAIN_W]);
  endfunction

  function automatic logic model_busy();
    for (int c = 0; c < NUM_CH; c++)
      if (gain_m[c] != eff_of(c)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    ch_m = 0;
    for (int c = 0; c < NUM_CH; c++) gain_m[c] = 0;
  endtask

  task automatic model_accept();
    longint d, q;
    int     delta;
    logic   sat;
    d = longint'(s_axis_data);
    if (s_axis_data[DATA_W-1]) d = d - (longint'(1) << DATA_W);
    q   = (d * longint'(gain_m[ch_m])) >>> FRAC_W;   // floor of d*g / 2^FRAC_W
    sat = 1'b0;
    if (q > (longint'(1) << (DATA_W-1)) - 1) begin q = (longint'(1) << (DATA_W-1)) - 1; sat = 1'b1; end
    if (q < -(longint'(1) << (DATA_W-1)))    begin q = -(longint'(1) << (DATA_W-1));    sat = 1'b1; end
    exp_q.push_back({sat, s_axis_last, q[DATA_W-1:0]});
    if (s_axis_last) begin
      if (ch_m != NUM_CH-1) exp_ferr = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        delta = eff_of(c) - gain_m[c];
        if (delta >  RAMP_STEP) delta =  RAMP_STEP;
        if (delta < -RAMP_STEP) delta = -RAMP_STEP;
        gain_m[c] += delta;
      end
      ch_m = 0;
    end else begin
      ch_m = (ch_m + 1) % NUM_CH;
    end
  endtask

  // ---------------- one clock cycle ----------------
  // Inputs are set by the caller. The task checks the outputs, then updates the
  // model for whatever transfers at the coming edge.
  task automatic tick();
    logic          exp_ready;
    logic [QW-1:0] head;
    bit            in_fire;
    #1;
    exp_ready = !axis_reset && !(m_axis_valid && !m_axis_ready);
    if (checking) begin
      check("s_axis_ready", s_axis_ready, exp_ready);
      check("ramp_busy", ramp_busy, model_busy());
      check("frame_err", frame_err, exp_ferr);
      if (stalled_prev) begin
        check("stall_valid", m_axis_valid, 1'b1);
        check("stall_data", m_axis_data, prev_data);
        check("stall_last", m_axis_last, prev_last);
      end
      if (m_axis_valid && !stalled_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_axis_valid, 1'b0);
        end else begin
          head = exp_q[0];
          check("sat_pulse", sat_pulse, head[DATA_W+1]);
        end
      end else begin
        check("sat_pulse_idle", sat_pulse, 1'b0);
      end
      if (m_axis_valid && m_axis_ready && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        check("m_axis_data", m_axis_data, head[DATA_W-1:0]);
        check("m_axis_last", m_axis_last, head[DATA_W]);
        out_log.push_back({sat_pulse, m_axis_last, m_axis_data});
      end
    end
    in_fire      = s_axis_valid && exp_ready;
    last_in_fire = in_fire;
    stalled_prev = m_axis_valid && !m_axis_ready && !axis_reset;
    prev_data    = m_axis_data;
    prev_last    = m_axis_last;
    exp_ferr     = 1'b0;
    if (axis_reset) begin
      model_reset();
      stalled_prev = 1'b0;
    end else if (in_fire) begin
      model_accept();
    end
    @(posedge axis_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    tick();
    s_axis_valid = 1'b0;
  endtask

  task automatic ramp_frames(input int n);
    for (int f = 0; f < n; f++) begin
      send_beat('0, 1'b0);
      send_beat('0, 1'b1);
    end
  endtask

  task automatic flush();
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("flush_empty", exp_q.size(), 0);
  endtask

  task automatic set_gain(input int g0, input int g1);
    gain_target = {GAIN_W'(g1), GAIN_W'(g0)};
  endtask

  task automatic log_check(input string tag, input int idx, input logic [DATA_W-1:0] d,
                           input logic l, input logic s);
    logic [QW-1:0] e;
    e = (idx < out_log.size()) ? out_log[idx] : 'x;
    check({tag, "_data"}, e[DATA_W-1:0], d);
    check({tag, "_last"}, e[DATA_W], l);
    check({tag, "_sat"}, e[DATA_W+1], s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int frames;
    int gen_ch;
    n_checks = 0; n_pass = 0; n_fail = 0; n_prints = 0;
    checking = 0; exp_ferr = 0; stalled_prev = 0; last_in_fire = 0;
    prev_data = '0; prev_last = 1'b0;
    axis_reset = 1'b1; mute = 1'b0; set_gain(16384, 16384);
    s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; m_axis_ready = 1'b1;
    model_reset();
    tick();
    tick();
    checking = 1;

    // Reset state
    check("rst_m_valid", m_axis_valid, 1'b0);
    check("rst_m_data", m_axis_data, '0);
    check("rst_m_last", m_axis_last, 1'b0);
    check("rst_sat", sat_pulse, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", ramp_busy, 1'b1);
    axis_reset = 1'b0;

    // Fade in from silence: exactly 256 frames to unity
    ramp_frames(255);
    check("ramp_255_busy", ramp_busy, 1'b1);
    ramp_frames(1);
    check("ramp_256_idle", ramp_busy, 1'b0);
    flush(); out_log.delete();

    // Unity gain, bit-exact, latency 2
    send_beat(24'h123456, 1'b0);
    check("lat_1_valid", m_axis_valid, 1'b0);
    send_beat(24'hFEDCBA, 1'b1);
    check("lat_2_valid", m_axis_valid, 1'b1);
    check("lat_2_data", m_axis_data, 24'h123456);
    tick();
    check("unity_ch1_data", m_axis_data, 24'hFEDCBA);
    check("unity_ch1_last", m_axis_last, 1'b1);
    flush();
    log_check("unity0", 0, 24'h123456, 1'b0, 1'b0);
    log_check("unity1", 1, 24'hFEDCBA, 1'b1, 1'b0);

    // Small target change settles in a single frame
    set_gain(16400, 16400);
    #1 check("step16_busy", ramp_busy, 1'b1);
    ramp_frames(1);
    check("step16_idle", ramp_busy, 1'b0);
    set_gain(16384, 16384);
    ramp_frames(1);

    // Mute: 256 frames down to zero
    mute = 1'b1;
    ramp_frames(255);
    check("mute_255_busy", ramp_busy, 1'b1);
    ramp_frames(1);
    check("mute_256_idle", ramp_busy, 1'b0);

    // Gain 0.5
    mute = 1'b0; set_gain(8192, 8192);
    ramp_frames(128);
    check("half_idle", ramp_busy, 1'b0);
    flush(); out_log.delete();
    send_beat(24'h400000, 1'b0); send_beat(24'hC00000, 1'b1);
    send_beat(24'h000001, 1'b0); send_beat(24'hFFFFFF, 1'b1);
    flush();
    log_check("half0", 0, 24'h200000, 1'b0, 1'b0);
    log_check("half1", 1, 24'hE00000, 1'b1, 1'b0);
    log_check("half2", 2, 24'h000000, 1'b0, 1'b0);
    log_check("half3", 3, 24'hFFFFFF, 1'b1, 1'b0);

    // Early last: frame_err pulse, next beat is channel 0
    set_gain(16384, 8192);
    ramp_frames(128);
    flush(); out_log.delete();
    send_beat(24'h100000, 1'b1);
    check("ferr_pulse", frame_err, 1'b1);
    send_beat(24'h100000, 1'b0);
    check("ferr_clear", frame_err, 1'b0);
    send_beat(24'h100000, 1'b1);
    flush();
    log_check("ferr0", 0, 24'h100000, 1'b1, 1'b0);
    log_check("ferr1", 1, 24'h100000, 1'b0, 1'b0);
    log_check("ferr2", 2, 24'h080000, 1'b1, 1'b0);

    // Gain 2.0 with saturation
    set_gain(32768, 32768);
    ramp_frames(384);
    check("dbl_idle", ramp_busy, 1'b0);
    flush(); out_log.delete();
    send_beat(24'h600000, 1'b0); send_beat(24'hA00000, 1'b1);
    send_beat(24'h100000, 1'b0); send_beat(24'h000000, 1'b1);
    flush();
    log_check("dbl0", 0, 24'h7FFFFF, 1'b0, 1'b1);
    log_check("dbl1", 1, 24'h800000, 1'b1, 1'b1);
    log_check("dbl2", 2, 24'h200000, 1'b0, 1'b0);

    // Reset with beats in flight and ch_idx mid-frame
    send_beat(24'h400000, 1'b0); send_beat(24'h400000, 1'b1); send_beat(24'h400000, 1'b0);
    check("inflight_valid", m_axis_valid, 1'b1);
    axis_reset = 1'b1;
    tick();
    check("midrst_valid", m_axis_valid, 1'b0);
    check("midrst_busy", ramp_busy, 1'b1);
    axis_reset = 1'b0;
    set_gain(16384, 0);
    ramp_frames(1);
    flush(); out_log.delete();
    send_beat(24'h400000, 1'b0); send_beat(24'h400000, 1'b1);
    flush();
    log_check("postrst0", 0, 24'h004000, 1'b0, 1'b0);
    log_check("postrst1", 1, 24'h000000, 1'b1, 1'b0);

    // Random stream with ~50% backpressure
    frames = 0; gen_ch = 0; last_in_fire = 0;
    set_gain($urandom_range(0, 40000), $urandom_range(0, 40000));
    for (int cyc = 0; cyc < 20000 && frames < 1000; cyc++) begin
      if (!s_axis_valid || last_in_fire) begin
        s_axis_valid = ($urandom_range(0, 3) != 0);
        s_axis_data  = DATA_W'($urandom_range(0, 24'hFFFFFF));
        if (gen_ch == NUM_CH-1) s_axis_last = ($urandom_range(0, 19) != 0);
        else                    s_axis_last = ($urandom_range(0, 29) == 0);
      end
      m_axis_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) set_gain($urandom_range(0, 40000), $urandom_range(0, 40000));
      if ($urandom_range(0, 499) == 0) mute = ~mute;
      tick();
      if (last_in_fire) begin
        if (s_axis_last) frames++;
        gen_ch = (s_axis_last || gen_ch == NUM_CH-1) ? 0 : gen_ch + 1;
      end
    end
    check("random_frames", frames, 1000);
    flush();

    if (n_fail == 0) $display("TEST PASSED: %0d failures, %0d/%0d checks passed", n_fail, n_pass, n_checks);
    else             $display("TEST FAILED: %0d failures, %0d/%0d checks passed", n_fail, n_pass, n_checks);
    $finish;
  end
endmodule
